instr_fetch_unit: RTL

- Memory-side responder for the program counter's fetch address.
- Takes the next-fetch address each cycle and returns the 32-bit instruction from a single-entry tagged buffer, or from a request/acknowledge bus read on a miss.
- Drives the freeze line back to the program counter while a fetch is outstanding.
- Sits between the PC/decode stage and the instruction-memory bus.

---
 rtl/instr_fetch_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Single-entry tagged instruction buffer with a req/ack bus refill
//            path. Freezes the PC while a refill is outstanding.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic [31:0] fetch_addr,
    input  logic        flush,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        freeze,
    output logic        fetch_error
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [31:0]        r_tag;
    logic               r_tag_valid;
    logic [31:0]        r_buffer;
    logic [31:0]        r_req_addr;
    logic               r_flushed;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_to_err;

    logic [1:0]         w_state_nxt;
    logic [31:0]        w_tag_nxt;
    logic               w_tag_valid_nxt;
    logic [31:0]        w_buffer_nxt;
    logic [31:0]        w_req_addr_nxt;
    logic               w_flushed_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_to_err_nxt;
    logic               w_aligned;
    logic               w_hit;
    logic               w_flush_seen;

    assign w_aligned    = (fetch_addr[1:0] == 2'b00);
    assign w_hit        = r_tag_valid && (r_tag == fetch_addr);
    assign w_flush_seen = r_flushed | flush;
    assign bus_addr     = r_req_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_tag       <= 32'h0;
            r_tag_valid <= 1'b0;
            r_buffer    <= 32'h0;
            r_req_addr  <= 32'h0;
            r_flushed   <= 1'b0;
            r_cnt       <= '0;
            r_to_err    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tag       <= w_tag_nxt;
            r_tag_valid <= w_tag_valid_nxt;
            r_buffer    <= w_buffer_nxt;
            r_req_addr  <= w_req_addr_nxt;
            r_flushed   <= w_flushed_nxt;
            r_cnt       <= w_cnt_nxt;
            r_to_err    <= w_to_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_tag_nxt       = r_tag;
        w_tag_valid_nxt = r_tag_valid;
        w_buffer_nxt    = r_buffer;
        w_req_addr_nxt  = r_req_addr;
        w_flushed_nxt   = r_flushed;
        w_cnt_nxt       = r_cnt;
        w_to_err_nxt    = r_to_err;
        bus_req         = 1'b0;
        instruction     = r_buffer;
        instr_valid     = 1'b0;
        freeze          = 1'b0;
        fetch_error     = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_flushed_nxt = 1'b0;
                if (flush) begin
                    w_tag_valid_nxt = 1'b0;
                end else if (fetch_en) begin
                    if (!w_aligned) begin
                        instruction = NOP_INSTR;
                        instr_valid = 1'b1;
                        fetch_error = 1'b1;
                    end else if (w_hit) begin
                        instr_valid = 1'b1;
                    end else begin
                        freeze         = 1'b1;
                        w_req_addr_nxt = fetch_addr;
                        w_cnt_nxt      = '0;
                        w_state_nxt    = c_ST_REQ;
                    end
                end
            end

            c_ST_REQ: begin
                bus_req       = 1'b1;
                freeze        = 1'b1;
                w_flushed_nxt = w_flush_seen;
                if (flush) begin
                    w_tag_valid_nxt = 1'b0;
                end
                // An ack in the final timeout cycle still completes the fetch.
                if (bus_ack) begin
                    if (w_flush_seen) begin
                        w_tag_valid_nxt = 1'b0;
                        w_flushed_nxt   = 1'b0;
                        w_state_nxt     = c_ST_IDLE;
                    end else begin
                        w_buffer_nxt    = bus_rdata;
                        w_tag_nxt       = r_req_addr;
                        w_tag_valid_nxt = 1'b1;
                        w_state_nxt     = c_ST_DONE;
                    end
                end else if (r_cnt == c_CNT_LAST) begin
                    w_tag_valid_nxt = 1'b0;
                    if (w_flush_seen) begin
                        // Nobody is waiting for a flushed fetch; drop it quietly.
                        w_flushed_nxt = 1'b0;
                        w_state_nxt   = c_ST_IDLE;
                    end else begin
                        w_buffer_nxt = NOP_INSTR;
                        w_to_err_nxt = 1'b1;
                        w_state_nxt  = c_ST_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            c_ST_DONE: begin
                instr_valid  = 1'b1;
                fetch_error  = r_to_err;
                w_to_err_nxt = 1'b0;
                w_state_nxt  = c_ST_IDLE;
                if (flush) begin
                    w_tag_valid_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
